lfsr_prbs_sync_check: RTL and testbench
=======================================

// Module: lfsr_prbs_sync_check
// PURPOSE
//  Self-synchronising PRBS checker that sits directly downstream of lfsr_prbs_gen,
//  either behind a loopback or at the far end of a link. It predicts each received
//  bit from previously received bits and flags mismatches per bit. It tracks lock
//  with a hunt/lock state machine and keeps saturating bit- and word-error counters.
// PARAMETERS
//  LFSR_WIDTH    31             PRBS order W
//  LFSR_POLY     31'h10000001   taps: bit i set => term b[n-(W-i)]; x^W implicit
//  LFSR_CONFIG   "FIBONACCI"    only FIBONACCI legal; any other value => $error at elaboration
//  REVERSE       0              0: data_in[DATA_WIDTH-1] is earliest bit; 1: data_in[0] earliest
//  DATA_WIDTH    64             bits per received word
//  LOCK_COUNT    16             consecutive clean words needed to declare lock
//  UNLOCK_COUNT  4              consecutive errored words needed to drop lock
//  ERR_CNT_WIDTH 32             width of the error counters
// PORTS
//  clk             in   1              clock; all logic rising-edge
//  rst_n           in   1              asynchronous, active-low reset
//  data_in         in   DATA_WIDTH     received PRBS word
//  data_in_valid   in   1              word qualifier; no backpressure
//  clear           in   1              synchronous pulse; zeroes both counters
//  error_out       out  DATA_WIDTH     per-bit mismatch, same bit order as data_in
//  error_valid     out  1              error_out qualifier
//  locked          out  1              FSM is in LOCKED
//  bit_err_count   out  ERR_CNT_WIDTH  saturating count of mismatched bits
//  word_err_count  out  ERR_CNT_WIDTH  saturating count of errored words
// BEHAVIOUR
//  - Reset: every output is 0, history register is 0, FSM is PRIME. Asserting reset
//    mid-operation discards all state; after release the checker re-primes.
//  - Predictor: form stream S = {history[W-1:0], word bits in time order}.
//    pred[n] = XOR of S[n-(W-i)] over the set bits i of LFSR_POLY.
//    err[n] = S[n] ^ pred[n]. Inputs are received bits only, so there is no recursion.
//  - After each valid word, history holds the last W received bits.
//  - Stuck-at-zero check, active when DATA_WIDTH >= W: an all-zero word forces
//    error_out = all ones and counts as an errored word. A valid PRBS never has a
//    run of W zeros.
//  - Latency: error_out and error_valid are registered 1 cycle after data_in_valid.
//    The FSM and counters update on that same edge.
//  - FSM:
//    PRIME -> HUNT after ceil(W/DATA_WIDTH) valid words. error_valid stays low
//    and counters are frozen while in PRIME.
//    HUNT: a clean word increments run; an errored word zeroes run.
//    run == LOCK_COUNT -> LOCKED, run cleared.
//    LOCKED: an errored word increments bad; a clean word zeroes bad.
//    bad == UNLOCK_COUNT -> HUNT.
//  - A cycle with data_in_valid = 0 changes no state and holds error_valid low.
//  - Counters accumulate only for words accepted while the FSM is LOCKED, including
//    the word that causes the unlock.
//    bit_err_count += popcount(err). word_err_count += (err != 0).
//    Both saturate at all ones with no wrap.
//  - clear in the same cycle as an increment: result is 0, the increment is dropped.
//    clear does not affect the FSM or error_out.
//  - Error multiplication is expected: one flipped line bit yields 1 + popcount(LFSR_POLY)
//    error bits (3 for PRBS31), which may straddle two words.
// STRUCTURE
//  - lfsr_prbs_pkg holds:
//    state encoding localparams (PRIME/HUNT/LOCKED);
//    popcount function;
//    ceil-div constant function.
//  - Sub-module lfsr_prbs_sync_predict: combinational {history, word} -> err word,
//    next history. It is parameterised identically and reusable by a future
//    Galois-mode checker.
//  - The top level holds the FSM, run/bad counters, input/output registers and
//    error counters.
// TESTING
//  1. Feed lfsr_prbs_gen output (PRBS31, 64b) with valid continuously.
//     -> locked rises on the edge registering the 17th word (1 priming word + 16
//     clean words); error_out is always 0; counters stay 0.
//  2. Once locked, flip the earliest bit of one word.
//     -> that word's error_out has exactly 3 bits set (stream offsets 0, 3, 31);
//     bit_err_count = 3, word_err_count = 1; locked stays 1.
//  3. Once locked, drive 4 consecutive all-zero words.
//     -> error_out = all ones each word; locked falls after the 4th;
//     word_err_count = 4, bit_err_count = 256.
//  4. Preload counters to all ones minus 1, then inject one error word.
//     -> both counters read all ones and hold there.
//     clear coincident with an error -> both read 0 next cycle.
//  5. Gaps: toggle data_in_valid randomly on a clean stream.
//     -> results are identical to the gapless run.
//     Assert rst_n low mid-stream -> all outputs are 0 asynchronously;
//     after release, re-prime and re-lock as in scenario 1.
//  6. REVERSE=1 with the generator also set to REVERSE=1 -> scenarios 1 and 2
//     repeat; the scenario-2 error bits appear at data_in[0], [3], [31].

Source files
------------

// File: rtl/lfsr_prbs_pkg.sv
// Shared definitions for the PRBS checker family.
//  - chk_state_e : checker lock state (PRIME / HUNT / LOCKED) with fixed encodings
//  - popcount()  : number of set bits in a word of up to MaxPopWidth bits
//  - ceil_div()  : constant-friendly ceiling division
package lfsr_prbs_pkg;

  localparam logic [1:0] StatePrime  = 2'd0;
  localparam logic [1:0] StateHunt   = 2'd1;
  localparam logic [1:0] StateLocked = 2'd2;

  typedef enum logic [1:0] {
    StPrime  = StatePrime,
    StHunt   = StateHunt,
    StLocked = StateLocked
  } chk_state_e;

  // Widest word popcount() accepts; callers zero-extend into it.
  localparam int unsigned MaxPopWidth = 1024;

  function automatic int unsigned popcount(input logic [MaxPopWidth-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MaxPopWidth; i++) begin
      cnt += 32'(v[i]);
    end
    return cnt;
  endfunction

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/lfsr_prbs_sync_predict.sv
// Combinational self-synchronising predictor.
// Builds the stream {hist_i, word bits in time order}, predicts every word bit from the
// LFSR_WIDTH bits before it and reports the per-bit mismatch.
//  hist_i : last LFSR_WIDTH received bits, hist_i[LFSR_WIDTH-1] oldest
//  data_i : received word (bit order selected by REVERSE)
//  err_o  : per-bit mismatch, same bit order as data_i
//  hist_o : history after this word has been consumed
module lfsr_prbs_sync_predict #(
  parameter int unsigned            LFSR_WIDTH  = 31,
  parameter logic [LFSR_WIDTH-1:0]  LFSR_POLY   = 31'h10000001,
  parameter string                  LFSR_CONFIG = "FIBONACCI",
  parameter bit                     REVERSE     = 1'b0,
  parameter int unsigned            DATA_WIDTH  = 64
) (
  input  logic [LFSR_WIDTH-1:0] hist_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] err_o,
  output logic [LFSR_WIDTH-1:0] hist_o
);

  if (LFSR_CONFIG != "FIBONACCI") begin : g_bad_config
    $error("lfsr_prbs_sync_predict: only FIBONACCI configuration is supported");
  end

  localparam int unsigned SLen = LFSR_WIDTH + DATA_WIDTH;

  // s[k]: k in [0, W) is history (oldest first), k = W + n is word bit n in time order.
  logic [SLen-1:0]       s;
  logic [DATA_WIDTH-1:0] err_t;  // mismatch in time order

  always_comb begin
    s = '0;
    for (int k = 0; k < LFSR_WIDTH; k++) begin
      s[k] = hist_i[LFSR_WIDTH-1-k];
    end
    for (int n = 0; n < DATA_WIDTH; n++) begin
      s[LFSR_WIDTH+n] = REVERSE ? data_i[n] : data_i[DATA_WIDTH-1-n];
    end

    // Tap i refers to b[n-(W-i)], which sits at s[n+i] for word bit n.
    err_t = '0;
    for (int n = 0; n < DATA_WIDTH; n++) begin
      err_t[n] = s[LFSR_WIDTH+n];
      for (int i = 0; i < LFSR_WIDTH; i++) begin
        if (LFSR_POLY[i]) begin
          err_t[n] = err_t[n] ^ s[n+i];
        end
      end
    end

    // A word of W or more zeros can never be valid PRBS, yet it predicts itself cleanly
    // once the history is zero; force it to show as fully errored.
    if ((DATA_WIDTH >= LFSR_WIDTH) && (data_i == '0)) begin
      err_t = '1;
    end

    err_o = '0;
    for (int n = 0; n < DATA_WIDTH; n++) begin
      if (REVERSE) begin
        err_o[n] = err_t[n];
      end else begin
        err_o[DATA_WIDTH-1-n] = err_t[n];
      end
    end

    hist_o = '0;
    for (int j = 0; j < LFSR_WIDTH; j++) begin
      hist_o[j] = s[SLen-1-j];
    end
  end

endmodule

// File: rtl/lfsr_prbs_sync_check.sv
// Self-synchronising PRBS checker with hunt/lock tracking and saturating error counters.
//  clk, rst_n     : clock, asynchronous active-low reset
//  data_in        : received PRBS word, qualified by data_in_valid (no backpressure)
//  clear          : synchronous pulse zeroing both error counters
//  error_out      : per-bit mismatch of the last accepted word, qualified by error_valid
//  locked         : checker is in LOCKED
//  bit_err_count  : saturating count of mismatched bits seen while locked
//  word_err_count : saturating count of errored words seen while locked
module lfsr_prbs_sync_check
  import lfsr_prbs_pkg::*;
#(
  parameter int unsigned            LFSR_WIDTH    = 31,
  parameter logic [LFSR_WIDTH-1:0]  LFSR_POLY     = 31'h10000001,
  parameter string                  LFSR_CONFIG   = "FIBONACCI",
  parameter bit                     REVERSE       = 1'b0,
  parameter int unsigned            DATA_WIDTH    = 64,
  parameter int unsigned            LOCK_COUNT    = 16,
  parameter int unsigned            UNLOCK_COUNT  = 4,
  parameter int unsigned            ERR_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_in_valid,
  input  logic                     clear,
  output logic [DATA_WIDTH-1:0]    error_out,
  output logic                     error_valid,
  output logic                     locked,
  output logic [ERR_CNT_WIDTH-1:0] bit_err_count,
  output logic [ERR_CNT_WIDTH-1:0] word_err_count
);

  if (LFSR_CONFIG != "FIBONACCI") begin : g_bad_config
    $error("lfsr_prbs_sync_check: only FIBONACCI configuration is supported");
  end

  localparam int unsigned PrimeWords = ceil_div(LFSR_WIDTH, DATA_WIDTH);
  localparam int unsigned PrimeW     = $clog2(PrimeWords + 1);
  localparam int unsigned RunW       = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BadW       = $clog2(UNLOCK_COUNT + 1);
  // Sum width wide enough for counter plus a full-word popcount without wrapping.
  localparam int unsigned SumW       = ((ERR_CNT_WIDTH > 32) ? ERR_CNT_WIDTH : 32) + 1;

  chk_state_e               state_q, state_d;
  logic [PrimeW-1:0]        prime_q, prime_d, prime_inc;
  logic [RunW-1:0]          run_q, run_d, run_inc;
  logic [BadW-1:0]          bad_q, bad_d, bad_inc;
  logic [LFSR_WIDTH-1:0]    hist_q, hist_d;
  logic [DATA_WIDTH-1:0]    err_q, err_d;
  logic                     err_valid_q, err_valid_d;
  logic [ERR_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

  logic [DATA_WIDTH-1:0]    pred_err;
  logic [LFSR_WIDTH-1:0]    pred_hist;
  logic                     word_bad;
  int unsigned              pop;
  logic [SumW-1:0]          bit_sum;

  lfsr_prbs_sync_predict #(
    .LFSR_WIDTH  (LFSR_WIDTH),
    .LFSR_POLY   (LFSR_POLY),
    .LFSR_CONFIG (LFSR_CONFIG),
    .REVERSE     (REVERSE),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_predict (
    .hist_i (hist_q),
    .data_i (data_in),
    .err_o  (pred_err),
    .hist_o (pred_hist)
  );

  always_comb begin
    prime_inc = prime_q + PrimeW'(1);
    run_inc   = run_q + RunW'(1);
    bad_inc   = bad_q + BadW'(1);
    word_bad  = |pred_err;
    pop       = popcount(MaxPopWidth'(pred_err));
    bit_sum   = SumW'(bit_cnt_q) + SumW'(pop);

    state_d     = state_q;
    prime_d     = prime_q;
    run_d       = run_q;
    bad_d       = bad_q;
    hist_d      = hist_q;
    err_d       = err_q;
    err_valid_d = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;

    if (data_in_valid) begin
      hist_d = pred_hist;
      err_d  = pred_err;
      unique case (state_q)
        StPrime: begin
          if (prime_inc == PrimeW'(PrimeWords)) begin
            state_d = StHunt;
            prime_d = '0;
          end else begin
            prime_d = prime_inc;
          end
        end
        StHunt: begin
          err_valid_d = 1'b1;
          if (word_bad) begin
            run_d = '0;
          end else if (run_inc == RunW'(LOCK_COUNT)) begin
            state_d = StLocked;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        StLocked: begin
          err_valid_d = 1'b1;
          // Counted before any unlock so the word that drops lock is included.
          if (bit_sum > SumW'({ERR_CNT_WIDTH{1'b1}})) begin
            bit_cnt_d = '1;
          end else begin
            bit_cnt_d = bit_sum[ERR_CNT_WIDTH-1:0];
          end
          if (word_bad && !(&word_cnt_q)) begin
            word_cnt_d = word_cnt_q + ERR_CNT_WIDTH'(1);
          end
          if (!word_bad) begin
            bad_d = '0;
          end else if (bad_inc == BadW'(UNLOCK_COUNT)) begin
            state_d = StHunt;
            bad_d   = '0;
          end else begin
            bad_d = bad_inc;
          end
        end
        default: begin
          state_d = StPrime;
        end
      endcase
    end

    // clear wins over a same-cycle increment.
    if (clear) begin
      bit_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPrime;
      prime_q     <= '0;
      run_q       <= '0;
      bad_q       <= '0;
      hist_q      <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      prime_q     <= prime_d;
      run_q       <= run_d;
      bad_q       <= bad_d;
      hist_q      <= hist_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign error_out      = err_q;
  assign error_valid    = err_valid_q;
  assign locked         = (state_q == StLocked);
  assign bit_err_count  = bit_cnt_q;
  assign word_err_count = word_cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_sync_check.sv
// Bench for lfsr_prbs_sync_check: one forward-order and one reverse-order checker see the
// same PRBS31 bit stream. A stream-level model queues the expected result of every word
// that should produce error_valid; a monitor pops and compares whenever the DUTs present one.
module tb_lfsr_prbs_sync_check;

  localparam int          W           = 31;
  localparam int          D           = 64;
  localparam logic [W-1:0] POLY       = 31'h10000001;
  localparam int          LOCK        = 16;
  localparam int          UNLOCK      = 4;
  localparam int          CW          = 10;
  localparam int          CMAX        = (1 << CW) - 1;
  localparam int          PRIME_WORDS = (W + D - 1) / D;

  typedef struct {
    logic [D-1:0] et;  // expected mismatch, time order
    bit           lk;
    int           bc;
    int           wc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [D-1:0]  data_in_f, data_in_r;
  logic          data_in_valid, clear;
  logic [D-1:0]  err_f, err_r;
  logic          ev_f, ev_r, lk_f, lk_r;
  logic [CW-1:0] bc_f, bc_r, wc_f, wc_r;

  always #5 clk = ~clk;

  lfsr_prbs_sync_check #(
    .LFSR_WIDTH (W), .LFSR_POLY (POLY), .LFSR_CONFIG ("FIBONACCI"), .REVERSE (1'b0),
    .DATA_WIDTH (D), .LOCK_COUNT (LOCK), .UNLOCK_COUNT (UNLOCK), .ERR_CNT_WIDTH (CW)
  ) u_dut_fwd (
    .clk (clk), .rst_n (rst_n), .data_in (data_in_f), .data_in_valid (data_in_valid),
    .clear (clear), .error_out (err_f), .error_valid (ev_f), .locked (lk_f),
    .bit_err_count (bc_f), .word_err_count (wc_f)
  );

  lfsr_prbs_sync_check #(
    .LFSR_WIDTH (W), .LFSR_POLY (POLY), .LFSR_CONFIG ("FIBONACCI"), .REVERSE (1'b1),
    .DATA_WIDTH (D), .LOCK_COUNT (LOCK), .UNLOCK_COUNT (UNLOCK), .ERR_CNT_WIDTH (CW)
  ) u_dut_rev (
    .clk (clk), .rst_n (rst_n), .data_in (data_in_r), .data_in_valid (data_in_valid),
    .clear (clear), .error_out (err_r), .error_valid (ev_r), .locked (lk_r),
    .bit_err_count (bc_r), .word_err_count (wc_r)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  exp_t   sb[$];
  exp_t   mon_e;
  bit     rx[$];           // received bits, time order
  int     mode;            // 0 prime, 1 hunt, 2 locked
  int     prime_n, run_n, bad_n, m_bc, m_wc;
  logic [W-1:0] gen_st;    // generator state, gen_st[k] = bit k+1 places back

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [D-1:0] rev_word(input logic [D-1:0] x);
    logic [D-1:0] r;
    for (int i = 0; i < D; i++) r[i] = x[D-1-i];
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_err_fwd"}, err_f, 64'd0);
    check({tag, "_err_rev"}, err_r, 64'd0);
    check({tag, "_valid_fwd"}, 64'(ev_f), 64'd0);
    check({tag, "_valid_rev"}, 64'(ev_r), 64'd0);
    check({tag, "_locked_fwd"}, 64'(lk_f), 64'd0);
    check({tag, "_locked_rev"}, 64'(lk_r), 64'd0);
    check({tag, "_bits_fwd"}, 64'(bc_f), 64'd0);
    check({tag, "_bits_rev"}, 64'(bc_r), 64'd0);
    check({tag, "_words_fwd"}, 64'(wc_f), 64'd0);
    check({tag, "_words_rev"}, 64'(wc_r), 64'd0);
  endtask

  task automatic check_counts(input string tag, input int bits, input int words);
    check({tag, "_bits_fwd"}, 64'(bc_f), 64'(bits));
    check({tag, "_bits_rev"}, 64'(bc_r), 64'(bits));
    check({tag, "_words_fwd"}, 64'(wc_f), 64'(words));
    check({tag, "_words_rev"}, 64'(wc_r), 64'(words));
  endtask

  task automatic check_locked(input string tag, input bit exp);
    check({tag, "_locked_fwd"}, 64'(lk_f), 64'(exp));
    check({tag, "_locked_rev"}, 64'(lk_r), 64'(exp));
  endtask

  task automatic model_reset();
    rx.delete();
    for (int k = 0; k < W; k++) rx.push_back(1'b0);
    mode = 0; prime_n = 0; run_n = 0; bad_n = 0; m_bc = 0; m_wc = 0;
  endtask

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  // Next D bits of the transmitted PRBS, time order in tw[0..D-1].
  task automatic gen_word(output logic [D-1:0] tw);
    for (int n = 0; n < D; n++) begin
      logic b;
      b = 1'b0;
      for (int i = 0; i < W; i++) if (POLY[i]) b ^= gen_st[W-1-i];
      tw[n]  = b;
      gen_st = {gen_st[W-2:0], b};
    end
  endtask

  task automatic model_word(input logic [D-1:0] tw, input bit clr);
    logic [D-1:0] et;
    int   base;
    bit   errd;
    bit   was_prime;
    exp_t e;
    base = rx.size();
    for (int n = 0; n < D; n++) rx.push_back(tw[n]);
    for (int n = 0; n < D; n++) begin
      logic p;
      p = rx[base+n];
      for (int i = 0; i < W; i++) if (POLY[i]) p ^= rx[base+n-(W-i)];
      et[n] = p;
    end
    if (tw == '0) et = '1;
    while (rx.size() > W) void'(rx.pop_front());

    was_prime = (mode == 0);
    errd = (et != '0);
    if (mode == 0) begin
      prime_n++;
      if (prime_n == PRIME_WORDS) begin mode = 1; prime_n = 0; end
    end else begin
      if (mode == 2) begin
        m_bc = sat(m_bc + $countones(et));
        if (errd) m_wc = sat(m_wc + 1);
        if (!errd) bad_n = 0;
        else begin
          bad_n++;
          if (bad_n == UNLOCK) begin mode = 1; bad_n = 0; end
        end
      end else begin
        if (errd) run_n = 0;
        else begin
          run_n++;
          if (run_n == LOCK) begin mode = 2; run_n = 0; end
        end
      end
    end
    if (clr) begin m_bc = 0; m_wc = 0; end
    if (!was_prime) begin
      e.et = et; e.lk = (mode == 2); e.bc = m_bc; e.wc = m_wc;
      sb.push_back(e);
    end
  endtask

  // One clock of stimulus. kind: 0 clean, 1 flip time-bit pos, 2 all-zero word.
  task automatic drive(input bit v, input int kind, input int pos, input bit clr);
    logic [D-1:0] tw;
    @(posedge clk);
    #1;
    clear         = clr;
    data_in_valid = v;
    if (v) begin
      gen_word(tw);
      if (kind == 1) tw[pos] = ~tw[pos];
      else if (kind == 2) tw = '0;
      model_word(tw, clr);
    end else begin
      tw = {$urandom, $urandom};
      if (clr) begin m_bc = 0; m_wc = 0; end
    end
    data_in_r = tw;
    data_in_f = rev_word(tw);
  endtask

  // Register the last driven word, then sample its outputs.
  task automatic settle();
    drive(1'b0, 0, 0, 1'b0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && (ev_f || ev_r)) begin
      if (sb.size() == 0) begin
        check("spurious_valid_fwd", 64'(ev_f), 64'd0);
        check("spurious_valid_rev", 64'(ev_r), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("valid_fwd", 64'(ev_f), 64'd1);
        check("valid_rev", 64'(ev_r), 64'd1);
        check("err_fwd", err_f, rev_word(mon_e.et));
        check("err_rev", err_r, mon_e.et);
        check_locked("mon", mon_e.lk);
        check_counts("mon", mon_e.bc, mon_e.wc);
      end
    end
  end

  initial begin
    rst_n = 1'b0; data_in_valid = 1'b0; clear = 1'b0;
    data_in_f = '0; data_in_r = '0;
    gen_st = W'($urandom) | W'(1);
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Continuous clean stream: 1 priming word + 16 clean words to lock.
    repeat (20) drive(1'b1, 0, 0, 1'b0);
    settle();
    check_locked("s1", 1'b1);
    check_counts("s1", 0, 0);

    // Earliest bit of one word flipped.
    drive(1'b1, 1, 0, 1'b0);
    settle();
    check("s2_err_fwd", err_f, 64'h9000_0001_0000_0000);
    check("s2_err_rev", err_r, 64'h0000_0000_8000_0009);
    check_counts("s2", 3, 1);
    check_locked("s2", 1'b1);

    // Four all-zero words drop lock.
    repeat (3) drive(1'b1, 0, 0, 1'b0);
    drive(1'b0, 0, 0, 1'b1);
    repeat (4) drive(1'b1, 2, 0, 1'b0);
    settle();
    check("s3_err_fwd", err_f, {64{1'b1}});
    check_locked("s3", 1'b0);
    check_counts("s3", 256, 4);

    // Random gaps, errors and clears.
    for (int k = 0; k < 600; k++) begin
      int r, kind;
      r    = $urandom_range(0, 99);
      kind = (r < 5) ? 1 : ((r < 7) ? 2 : 0);
      drive($urandom_range(0, 99) < 70, kind, $urandom_range(0, D - 1),
            $urandom_range(0, 99) < 2);
    end

    // Saturation: stay locked with 3 errored words then 1 clean, repeated.
    drive(1'b0, 0, 0, 1'b1);
    repeat (24) drive(1'b1, 0, 0, 1'b0);
    for (int g = 0; g < 350; g++) begin
      repeat (3) drive(1'b1, 1, $urandom_range(0, 32), 1'b0);
      drive(1'b1, 0, 0, 1'b0);
    end
    settle();
    check_counts("sat", CMAX, CMAX);
    check_locked("sat", 1'b1);
    drive(1'b1, 1, 5, 1'b1);
    settle();
    check_counts("sat_clear", 0, 0);

    // Asynchronous reset mid-stream, then re-prime and re-lock with gaps.
    repeat (30) drive($urandom_range(0, 1) == 1, 0, 0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    sb.delete();
    model_reset();
    data_in_valid = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 1) == 1) drive(1'b0, 0, 0, 1'b0);
      drive(1'b1, 0, 0, 1'b0);
    end
    settle();
    check_locked("relock", 1'b1);

    repeat (3) drive(1'b0, 0, 0, 1'b0);
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
